// File: rtl/rx_freq_update_sched.sv
// Round-robin NCO frequency update scheduler for the rx DDC array.
// Coalesces per-channel retunes and issues them in bursts aligned to samp_strobe.
module rx_freq_update_sched #(
    parameter int N_CHANS      = 8,
    parameter int FREQ_BITS    = 48,
    parameter int MAX_PER_SLOT = 2,
    // one spare code point so an out-of-range channel is representable
    parameter int CHAN_BITS    = $clog2(N_CHANS + 1)
) (
    input  logic                 adc_clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [CHAN_BITS-1:0] cmd_chan,
    input  logic [FREQ_BITS-1:0] cmd_freq,
    input  logic                 samp_strobe,
    output logic                 nco_wr,
    output logic [N_CHANS-1:0]   nco_sel,
    output logic [FREQ_BITS-1:0] nco_freq,
    output logic [N_CHANS-1:0]   pending,
    output logic                 busy,
    output logic                 overrun,
    output logic                 cmd_err,
    output logic [15:0]          coalesce_cnt
);

    localparam int PTR_BITS = $clog2(N_CHANS);
    localparam int CNT_BITS = $clog2(MAX_PER_SLOT + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state, state_nxt;
    logic [PTR_BITS-1:0]  rr_ptr;
    logic [PTR_BITS-1:0]  sel;
    logic [PTR_BITS-1:0]  cmd_idx;
    logic [CNT_BITS-1:0]  wr_cnt;
    logic [FREQ_BITS-1:0] store [N_CHANS];
    logic [N_CHANS-1:0]   pending_nxt;
    logic                 found;
    logic                 do_issue;
    logic                 cmd_ok;
    logic                 hit;
    int                   idx;

    assign cmd_ok  = cmd_valid && (cmd_chan < CHAN_BITS'(N_CHANS));
    assign cmd_idx = cmd_chan[PTR_BITS-1:0];
    assign hit     = do_issue && cmd_ok && (sel == cmd_idx);
    assign busy    = (state == ISSUE);

    // first pending channel at or after rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < N_CHANS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_CHANS) idx = idx - N_CHANS;
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = PTR_BITS'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        do_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (samp_strobe && found) begin
                    do_issue  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (found && wr_cnt < CNT_BITS'(MAX_PER_SLOT)) begin
                    do_issue = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // a new command re-arms its channel even if it is being issued now
    always_comb begin
        pending_nxt = pending;
        if (do_issue) pending_nxt[sel] = 1'b0;
        if (cmd_ok) pending_nxt[cmd_idx] = 1'b1;
    end

    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            wr_cnt       <= '0;
            pending      <= '0;
            nco_wr       <= 1'b0;
            nco_sel      <= '0;
            nco_freq     <= '0;
            overrun      <= 1'b0;
            cmd_err      <= 1'b0;
            coalesce_cnt <= '0;
            for (int i = 0; i < N_CHANS; i++) store[i] <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            nco_wr  <= do_issue;
            overrun <= samp_strobe && (state == ISSUE);
            cmd_err <= cmd_valid && !cmd_ok;
            if (do_issue) begin
                nco_sel  <= N_CHANS'(1) << sel;
                nco_freq <= store[sel];
                rr_ptr   <= (sel == PTR_BITS'(N_CHANS - 1)) ? '0 : sel + 1'b1;
                wr_cnt   <= (state == IDLE) ? CNT_BITS'(1) : wr_cnt + 1'b1;
            end
            if (cmd_ok) begin
                store[cmd_idx] <= cmd_freq;
                if (pending[cmd_idx] && !hit && coalesce_cnt != 16'hFFFF)
                    coalesce_cnt <= coalesce_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_freq_update_sched.sv
// Directed table-driven bench for rx_freq_update_sched (N=8, MAX=2).
// Plus hand sequences for counter saturation and mid-burst reset.
module tb_rx_freq_update_sched;

    logic        adc_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [3:0]  cmd_chan;
    logic [47:0] cmd_freq;
    logic        samp_strobe;
    logic        nco_wr;
    logic [7:0]  nco_sel;
    logic [47:0] nco_freq;
    logic [7:0]  pending;
    logic        busy;
    logic        overrun;
    logic        cmd_err;
    logic [15:0] coalesce_cnt;

    int checks = 0;
    int errors = 0;

    rx_freq_update_sched #(
        .N_CHANS(8),
        .FREQ_BITS(48),
        .MAX_PER_SLOT(2)
    ) dut (
        .adc_clk(adc_clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_chan(cmd_chan),
        .cmd_freq(cmd_freq),
        .samp_strobe(samp_strobe),
        .nco_wr(nco_wr),
        .nco_sel(nco_sel),
        .nco_freq(nco_freq),
        .pending(pending),
        .busy(busy),
        .overrun(overrun),
        .cmd_err(cmd_err),
        .coalesce_cnt(coalesce_cnt)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        logic        cv;
        logic [3:0]  ch;
        logic [47:0] fr;
        logic        stb;
        logic        wr;
        logic [7:0]  sel;
        logic [47:0] fo;
        logic [7:0]  pend;
        logic        bsy;
        logic        ovr;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic cv, input logic [3:0] ch, input logic [47:0] fr,
        input logic stb, input logic wr, input logic [7:0] sel,
        input logic [47:0] fo, input logic [7:0] pend, input logic bsy,
        input logic ovr, input logic err, input logic [15:0] cnt);
        vec_t v;
        v.cv = cv; v.ch = ch; v.fr = fr; v.stb = stb;
        v.wr = wr; v.sel = sel; v.fo = fo; v.pend = pend;
        v.bsy = bsy; v.ovr = ovr; v.err = err; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {nco_wr, nco_sel, nco_freq, pending, busy,
                overrun, cmd_err, coalesce_cnt};
    endfunction

    task automatic drive(input logic cv, input logic [3:0] ch,
                         input logic [47:0] fr, input logic stb);
        cmd_valid   = cv;
        cmd_chan    = ch;
        cmd_freq    = fr;
        samp_strobe = stb;
    endtask

    localparam logic [47:0] F3 = 48'h1234_5678_9ABC;

    initial begin
        logic [127:0] e;
        reset = 1'b1;
        drive(1'b0, 4'd0, 48'd0, 1'b0);
        repeat (2) @(posedge adc_clk);
        #1;
        check("reset_state", outs(), 128'd0);
        reset = 1'b0;

        // round robin: ch0,1,5,7 then ch0,6 after the pointer wrapped
        add(1,0,48'h100,0, 0,8'h00,48'h0,  8'h01,0,0,0,16'd0);
        add(1,1,48'h101,0, 0,8'h00,48'h0,  8'h03,0,0,0,16'd0);
        add(1,5,48'h105,0, 0,8'h00,48'h0,  8'h23,0,0,0,16'd0);
        add(1,7,48'h107,0, 0,8'h00,48'h0,  8'hA3,0,0,0,16'd0);
        add(0,0,48'h0,  1, 1,8'h01,48'h100,8'hA2,1,0,0,16'd0);
        add(0,0,48'h0,  0, 1,8'h02,48'h101,8'hA0,1,0,0,16'd0);
        add(0,0,48'h0,  0, 0,8'h02,48'h101,8'hA0,0,0,0,16'd0);
        add(0,0,48'h0,  1, 1,8'h20,48'h105,8'h80,1,0,0,16'd0);
        add(0,0,48'h0,  0, 1,8'h80,48'h107,8'h00,1,0,0,16'd0);
        add(1,0,48'h200,0, 0,8'h80,48'h107,8'h01,0,0,0,16'd0);
        add(1,6,48'h206,0, 0,8'h80,48'h107,8'h41,0,0,0,16'd0);
        add(0,0,48'h0,  1, 1,8'h01,48'h200,8'h40,1,0,0,16'd0);
        add(0,0,48'h0,  0, 1,8'h40,48'h206,8'h00,1,0,0,16'd0);
        add(0,0,48'h0,  0, 0,8'h40,48'h206,8'h00,0,0,0,16'd0);
        // single update on ch3
        add(1,3,F3,     0, 0,8'h40,48'h206,8'h08,0,0,0,16'd0);
        add(0,0,48'h0,  0, 0,8'h40,48'h206,8'h08,0,0,0,16'd0);
        add(0,0,48'h0,  1, 1,8'h08,F3,     8'h00,1,0,0,16'd0);
        add(0,0,48'h0,  0, 0,8'h08,F3,     8'h00,0,0,0,16'd0);
        // coalesce on ch2
        add(1,2,48'h10, 0, 0,8'h08,F3,     8'h04,0,0,0,16'd0);
        add(1,2,48'h20, 0, 0,8'h08,F3,     8'h04,0,0,0,16'd1);
        add(0,0,48'h0,  1, 1,8'h04,48'h20, 8'h00,1,0,0,16'd1);
        add(0,0,48'h0,  0, 0,8'h04,48'h20, 8'h00,0,0,0,16'd1);
        // collision on the last write of a burst
        add(1,3,48'h33, 0, 0,8'h04,48'h20, 8'h08,0,0,0,16'd1);
        add(1,4,48'hAA, 0, 0,8'h04,48'h20, 8'h18,0,0,0,16'd1);
        add(0,0,48'h0,  1, 1,8'h08,48'h33, 8'h10,1,0,0,16'd1);
        add(1,4,48'hBB, 0, 1,8'h10,48'hAA, 8'h10,1,0,0,16'd1);
        add(0,0,48'h0,  0, 0,8'h10,48'hAA, 8'h10,0,0,0,16'd1);
        add(0,0,48'h0,  1, 1,8'h10,48'hBB, 8'h00,1,0,0,16'd1);
        add(0,0,48'h0,  0, 0,8'h10,48'hBB, 8'h00,0,0,0,16'd1);
        // overrun, idle strobe, bad channel
        add(1,5,48'h55, 0, 0,8'h10,48'hBB, 8'h20,0,0,0,16'd1);
        add(1,6,48'h66, 0, 0,8'h10,48'hBB, 8'h60,0,0,0,16'd1);
        add(0,0,48'h0,  1, 1,8'h20,48'h55, 8'h40,1,0,0,16'd1);
        add(0,0,48'h0,  1, 1,8'h40,48'h66, 8'h00,1,1,0,16'd1);
        add(0,0,48'h0,  0, 0,8'h40,48'h66, 8'h00,0,0,0,16'd1);
        add(0,0,48'h0,  1, 0,8'h40,48'h66, 8'h00,0,0,0,16'd1);
        add(1,1,48'h11, 0, 0,8'h40,48'h66, 8'h02,0,0,0,16'd1);
        add(1,8,48'h99, 0, 0,8'h40,48'h66, 8'h02,0,0,1,16'd1);
        add(0,0,48'h0,  0, 0,8'h40,48'h66, 8'h02,0,0,0,16'd1);

        foreach (tbl[i]) begin
            drive(tbl[i].cv, tbl[i].ch, tbl[i].fr, tbl[i].stb);
            @(posedge adc_clk);
            #1;
            e = {tbl[i].wr, tbl[i].sel, tbl[i].fo, tbl[i].pend,
                 tbl[i].bsy, tbl[i].ovr, tbl[i].err, tbl[i].cnt};
            check($sformatf("row%0d", i), outs(), e);
        end

        // saturate the coalesce counter on the still-pending ch1
        drive(1'b1, 4'd1, 48'h77, 1'b0);
        repeat (65534) @(posedge adc_clk);
        #1;
        check("cnt_reach_ffff", {112'd0, coalesce_cnt}, {112'd0, 16'hFFFF});
        @(posedge adc_clk);
        #1;
        check("cnt_saturate", {104'd0, pending, coalesce_cnt},
              {104'd0, 8'h02, 16'hFFFF});

        // reset in the middle of a burst
        drive(1'b1, 4'd0, 48'h1, 1'b0);
        @(posedge adc_clk);
        #1;
        drive(1'b1, 4'd2, 48'h2, 1'b0);
        @(posedge adc_clk);
        #1;
        drive(1'b0, 4'd0, 48'h0, 1'b1);
        @(posedge adc_clk);
        #1;
        drive(1'b0, 4'd0, 48'h0, 1'b0);
        check("burst_start", {117'd0, nco_wr, nco_sel, busy, pending},
              {117'd0, 1'b1, 8'h01, 1'b1, 8'h06});
        #3;
        reset = 1'b1;
        #1;
        check("reset_mid_burst", outs(), 128'd0);
        @(posedge adc_clk);
        #1;
        reset = 1'b0;
        samp_strobe = 1'b1;
        @(posedge adc_clk);
        #1;
        samp_strobe = 1'b0;
        check("strobe_after_reset", {125'd0, nco_wr, busy, overrun},
              128'd0);
        @(posedge adc_clk);
        #1;
        check("idle_after_reset", outs(), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
